// File: rtl/dmem_pkg.sv
// Shared definitions for the block data memory: FSM state encoding, default
// geometry/latency and the block-width helper also used by the data cache.
package dmem_pkg;

    localparam int unsigned DMEM_BLOCK_SIZE = 32'd32;
    localparam int unsigned DMEM_MEM_SIZE   = 32'd16384;
    localparam int unsigned DMEM_LATENCY    = 32'd10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } dmem_state_e;

    function automatic int unsigned block_bits(input int unsigned block_bytes);
        return block_bytes * 32'd8;
    endfunction

endpackage

// File: rtl/dmem_block_array.sv
// Single-port block storage: one whole block per entry, synchronous write and
// registered read. Contents are never cleared by reset.
module dmem_block_array #(
    parameter  int unsigned pDepth = 32'd512,
    parameter  int unsigned pWidth = 32'd256,
    localparam int unsigned IDX_W  = (pDepth > 32'd1) ? $clog2(pDepth) : 32'd1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              rd_zero_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [pWidth-1:0] wdata_i,
    output logic [pWidth-1:0] rdata_o
);

    logic [pWidth-1:0] mem_r [pDepth];
    logic [pWidth-1:0] rdata_r;

    // Block write; a write coinciding with reset is dropped so aborted requests leave no trace
    always_ff @(posedge clk_i) begin
        if (rst_i && we_i) begin
            mem_r[idx_i] <= wdata_i;
        end
    end

    // Read register holds its value until the next read completes
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rdata_r <= '0;
        end else if (re_i) begin
            rdata_r <= rd_zero_i ? '0 : mem_r[idx_i];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/block_data_memory.sv
// Block-granular backing store answering data-cache refills and write-backs with a
// fixed latency. Optional out-of-range detection is enabled by DMEM_RANGE_CHECK_EN.
module block_data_memory
    import dmem_pkg::*;
#(
    parameter  int unsigned pBlockSize = DMEM_BLOCK_SIZE,
    parameter  int unsigned pMemSize   = DMEM_MEM_SIZE,
    parameter  int unsigned pLatency   = DMEM_LATENCY,
    localparam int unsigned BLK_W      = block_bits(pBlockSize),
    localparam int unsigned pDepth     = pMemSize / pBlockSize,
    localparam int unsigned IDX_W      = (pDepth > 32'd1) ? $clog2(pDepth) : 32'd1,
    localparam int unsigned CNT_W      = $clog2(pLatency + 32'd1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [31:0]       addr_i,
    input  logic              write_ctrl_i,
    input  logic [BLK_W-1:0]  write_data_i,
    output logic              ack_o,
    output logic [BLK_W-1:0]  read_data_o
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic              error_o
`endif
);

    localparam logic             DIRECT  = (pLatency == 32'd1);
    localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(pLatency - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    dmem_state_e        state_r;
    dmem_state_e        state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic               wr_r;
    logic [BLK_W-1:0]   wdata_r;
    logic               oor_r;
    logic               ack_r;

    logic               access_s;
    logic               in_oor_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic               acc_wr_s;
    logic [BLK_W-1:0]   acc_wdata_s;
    logic               acc_oor_s;
    logic               we_s;
    logic               re_s;

`ifdef DMEM_RANGE_CHECK_EN
    logic               oor_hit_r;
    logic               err_r;

    assign in_oor_s = |addr_i[31:IDX_W];
`else
    logic               unused_addr_hi_s;

    assign in_oor_s         = 1'b0;
    assign unused_addr_hi_s = ^addr_i[31:IDX_W];
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the counter marks the last busy cycle when it is about to reach zero
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (enable_i) begin
                    state_next_s = DIRECT ? ST_ACK : ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ONE) begin
                    state_next_s = ST_ACK;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_ACK: state_next_s = ST_RELEASE;
            ST_RELEASE: begin
                if (enable_i) begin
                    state_next_s = ST_RELEASE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Access strobe: a single-cycle latency works straight from the request inputs
    always_comb begin
        access_s = 1'b0;
        case (state_r)
            ST_IDLE: access_s = enable_i & DIRECT;
            ST_BUSY: access_s = (cnt_r == CNT_ONE);
            default: access_s = 1'b0;
        endcase
    end

    // Select the request copy used by the access
    always_comb begin
        acc_idx_s   = idx_r;
        acc_wr_s    = wr_r;
        acc_wdata_s = wdata_r;
        acc_oor_s   = oor_r;
        if (state_r == ST_IDLE) begin
            acc_idx_s   = addr_i[IDX_W-1:0];
            acc_wr_s    = write_ctrl_i;
            acc_wdata_s = write_data_i;
            acc_oor_s   = in_oor_s;
        end else begin
            acc_idx_s   = idx_r;
            acc_wr_s    = wr_r;
            acc_wdata_s = wdata_r;
            acc_oor_s   = oor_r;
        end
    end

    assign we_s = access_s & acc_wr_s & ~acc_oor_s;
    assign re_s = access_s & ~acc_wr_s;

    // Latency counter, loaded on capture and counted down while busy
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_r <= '0;
        end else if ((state_r == ST_IDLE) && enable_i) begin
            cnt_r <= LAT_M1;
        end else if (state_r == ST_BUSY) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request capture; later input changes are ignored until the next request
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            idx_r   <= '0;
            wr_r    <= 1'b0;
            wdata_r <= '0;
            oor_r   <= 1'b0;
        end else if ((state_r == ST_IDLE) && enable_i) begin
            idx_r   <= addr_i[IDX_W-1:0];
            wr_r    <= write_ctrl_i;
            wdata_r <= write_data_i;
            oor_r   <= in_oor_s;
        end else begin
            idx_r   <= idx_r;
            wr_r    <= wr_r;
            wdata_r <= wdata_r;
            oor_r   <= oor_r;
        end
    end

    // Acknowledge follows the access edge by one cycle so read data is already settled
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= (state_r == ST_ACK);
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    // Error flag rides on the acknowledge cycle of an out-of-range access
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            oor_hit_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            oor_hit_r <= access_s ? acc_oor_s : oor_hit_r;
            err_r     <= (state_r == ST_ACK) & oor_hit_r;
        end
    end

    assign error_o = err_r;
`endif

    dmem_block_array #(
        .pDepth (pDepth),
        .pWidth (BLK_W)
    ) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (we_s),
        .re_i      (re_s),
        .rd_zero_i (acc_oor_s),
        .idx_i     (acc_idx_s),
        .wdata_i   (acc_wdata_s),
        .rdata_o   (read_data_o)
    );

    assign ack_o = ack_r;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: one instance at latency 10, one at latency 1,
// sharing clock and reset. Range-check expectations follow DMEM_RANGE_CHECK_EN.
module tb_block_data_memory;

    localparam int unsigned BW = 256;
    localparam logic [BW-1:0] P_A5 = {32{8'hA5}};
    localparam logic [BW-1:0] P_3C = {32{8'h3C}};
    localparam logic [BW-1:0] P_FF = {32{8'hFF}};
    localparam logic [BW-1:0] P_11 = {32{8'h11}};
    localparam logic [BW-1:0] P_5A = {32{8'h5A}};
    localparam logic [BW-1:0] P_77 = {32{8'h77}};
    localparam logic [BW-1:0] P_88 = {32{8'h88}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_s = 1'b0;
    logic          en_a = 1'b0, wr_a = 1'b0, ack_a;
    logic [31:0]   addr_a = 32'd0;
    logic [BW-1:0] wd_a = '0, rd_a;
    logic          en_b = 1'b0, wr_b = 1'b0, ack_b;
    logic [31:0]   addr_b = 32'd0;
    logic [BW-1:0] wd_b = '0, rd_b;
`ifdef DMEM_RANGE_CHECK_EN
    logic          err_a, err_b;
    logic          exp_err_s = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    block_data_memory #(.pBlockSize(32'd32), .pMemSize(32'd16384), .pLatency(32'd10)) dut_a (
        .clk_i(clk), .rst_i(rst_s), .enable_i(en_a), .addr_i(addr_a), .write_ctrl_i(wr_a),
        .write_data_i(wd_a), .ack_o(ack_a), .read_data_o(rd_a)
`ifdef DMEM_RANGE_CHECK_EN
        , .error_o(err_a)
`endif
    );

    block_data_memory #(.pBlockSize(32'd32), .pMemSize(32'd16384), .pLatency(32'd1)) dut_b (
        .clk_i(clk), .rst_i(rst_s), .enable_i(en_b), .addr_i(addr_b), .write_ctrl_i(wr_b),
        .write_data_i(wd_b), .ack_o(ack_b), .read_data_o(rd_b)
`ifdef DMEM_RANGE_CHECK_EN
        , .error_o(err_b)
`endif
    );

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic en, input logic [31:0] addr,
                         input logic wr, input logic [BW-1:0] wd);
        if (sel) begin
            en_b = en; addr_b = addr; wr_b = wr; wd_b = wd;
        end else begin
            en_a = en; addr_a = addr; wr_a = wr; wd_a = wd;
        end
    endtask

    // One request: measures capture-to-ack latency, checks data, optional hold/early drop
    task automatic req(input bit sel, input logic [31:0] addr, input logic wr,
                       input logic [BW-1:0] wd, input int hold, input int drop_after,
                       input int exp_lat, input bit chk_rd, input logic [BW-1:0] exp_rd,
                       input string tag);
        int   k      = 0;
        int   pulses = 0;
        logic ack_s  = 1'b0;
        drive(sel, 1'b1, addr, wr, wd);
        while (!ack_s && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (drop_after > 0 && k == drop_after) drive(sel, 1'b0, addr, wr, wd);
            ack_s = sel ? ack_b : ack_a;
        end
        check({tag, "_lat"}, BW'(k - 1), BW'(exp_lat));
        if (chk_rd) check({tag, "_data"}, sel ? rd_b : rd_a, exp_rd);
`ifdef DMEM_RANGE_CHECK_EN
        check({tag, "_err"}, BW'(sel ? err_b : err_a), BW'(exp_err_s));
`endif
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                if (sel ? ack_b : ack_a) pulses++;
            end
            check({tag, "_extra_pulses"}, BW'(pulses), BW'(0));
        end
        drive(sel, 1'b0, addr, wr, wd);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int acks = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_s = 1'b1;
        check("rst_ack_a", BW'(ack_a), BW'(0));
        check("rst_rd_a", rd_a, '0);
        check("rst_ack_b", BW'(ack_b), BW'(0));
        check("rst_rd_b", rd_b, '0);
`ifdef DMEM_RANGE_CHECK_EN
        check("rst_err_a", BW'(err_a), BW'(0));
`endif
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            acks += int'(ack_a) + int'(ack_b);
        end
        check("idle_no_ack", BW'(acks), BW'(0));

        // Write/read round trip, hold-through-ack, and capture after one low cycle
        req(1'b0, 32'd5, 1'b1, P_A5, 0, 0, 10, 1'b0, '0, "wr5");
        req(1'b0, 32'd5, 1'b0, '0, 0, 0, 10, 1'b1, P_A5, "rd5");
        req(1'b0, 32'd7, 1'b1, P_3C, 0, 0, 10, 1'b1, P_A5, "wr7_rd_hold");
        req(1'b0, 32'd7, 1'b0, '0, 3, 0, 10, 1'b1, P_3C, "rd7_held_en");
        req(1'b0, 32'd5, 1'b0, '0, 0, 0, 10, 1'b1, P_A5, "rd5_after_low");

        // Reset four cycles into a write to index 7
        acks = 0;
        drive(1'b0, 1'b1, 32'd7, 1'b1, P_FF);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            acks += int'(ack_a);
        end
        rst_s = 1'b0;
        drive(1'b0, 1'b0, 32'd7, 1'b1, P_FF);
        @(posedge clk);
        @(negedge clk);
        rst_s = 1'b1;
        check("abort_rd_cleared", rd_a, '0);
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            acks += int'(ack_a);
        end
        check("abort_no_ack", BW'(acks), BW'(0));
        req(1'b0, 32'd7, 1'b0, '0, 0, 0, 10, 1'b1, P_3C, "rd7_after_abort");

        // Enable dropped while busy still completes the access
        req(1'b0, 32'd5, 1'b0, '0, 0, 3, 10, 1'b1, P_A5, "rd5_early_drop");

        // Address with a bit above the 9-bit index field
        req(1'b0, 32'd0, 1'b1, P_11, 0, 0, 10, 1'b0, '0, "wr0");
`ifdef DMEM_RANGE_CHECK_EN
        exp_err_s = 1'b1;
        req(1'b0, 32'h0000_0200, 1'b1, P_5A, 0, 0, 10, 1'b0, '0, "wr_oor");
        req(1'b0, 32'h0000_0200, 1'b0, '0, 0, 0, 10, 1'b1, '0, "rd_oor");
        exp_err_s = 1'b0;
        req(1'b0, 32'd0, 1'b0, '0, 0, 0, 10, 1'b1, P_11, "rd0_untouched");
`else
        req(1'b0, 32'h0000_0200, 1'b1, P_5A, 0, 0, 10, 1'b0, '0, "wr_alias");
        req(1'b0, 32'h0000_0200, 1'b0, '0, 0, 0, 10, 1'b1, P_5A, "rd_alias_hi");
        req(1'b0, 32'd0, 1'b0, '0, 0, 0, 10, 1'b1, P_5A, "rd0_aliased");
`endif

        // Single-cycle latency instance, back-to-back with one low cycle between
        req(1'b1, 32'd3, 1'b1, P_77, 0, 0, 1, 1'b0, '0, "b_wr3");
        req(1'b1, 32'd3, 1'b0, '0, 0, 0, 1, 1'b1, P_77, "b_rd3");
        req(1'b1, 32'd3, 1'b1, P_88, 0, 0, 1, 1'b1, P_77, "b_wr3_again");
        req(1'b1, 32'd3, 1'b0, '0, 0, 0, 1, 1'b1, P_88, "b_rd3_again");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_data_memory.md
# block_data_memory

Block-granular backing store that sits behind the data cache and answers its refill and write-back requests. The cache is the initiator; this block is the responder on the same enable/ack interface. It latches a request, models a fixed access latency, then performs a whole-block read or write and pulses an acknowledge. Storage is one block per entry; there is no byte or word addressing.

## Interface
- pBlockSize, 32: block size in bytes; power of two, ≥ 4.
- pMemSize, 16384: capacity in bytes; multiple of pBlockSize. pDepth = pMemSize / pBlockSize.
- pLatency, 10: cycles from request capture to ack_o; ≥ 1.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- enable_i  input  1  request valid; held high by the initiator until it samples ack_o.
- addr_i  input  32  block address (block index in the low bits, not a byte address).
- write_ctrl_i  input  1  1 = write block, 0 = read block.
- write_data_i  input  pBlockSize*8  block to store on a write.
- ack_o  output  1  one-cycle completion pulse.
- read_data_o  output  pBlockSize*8  block read; valid while ack_o is high.
- error_o  output  1  out-of-range flag; present only with DMEM_RANGE_CHECK_EN.

## Operation
- States: IDLE, BUSY, ACK, RELEASE.
- IDLE: if enable_i = 1, capture addr_i, write_ctrl_i, write_data_i; load the counter with pLatency−1; go to BUSY, or to ACK directly if pLatency = 1.
- BUSY: decrement the counter. Inputs are ignored, because the captured copy is used. At counter = 0, perform the access and go to ACK.
- Access: block index = captured addr[$clog2(pDepth)−1:0]. A write stores the full block. A read loads read_data_o.
- ACK: ack_o = 1 for exactly one cycle, then RELEASE.
- RELEASE: wait for enable_i = 0, then IDLE. This guarantees one request is served per enable assertion.
- read_data_o holds its value until the next read completes. A write leaves it unchanged.
- Write followed by a read of the same index returns the written block.

## Timing
- Reset (rst_i = 0 at an edge): state IDLE, ack_o = 0, read_data_o = 0, error_o = 0, counter = 0. Storage contents are not cleared.
- Reset mid-operation aborts the request. A pending write is dropped, and no ack is issued.
- Latency: request captured at edge N, ack_o high after edge N+pLatency.
- Earliest next capture: the edge after enable_i is first sampled low in RELEASE.
- enable_i dropping during BUSY does not cancel the access. The ack is still issued.
- Counter width: $clog2(pLatency+1) bits. It never wraps.

## Configuration
- DMEM_RANGE_CHECK_EN defined: address bits above the index field are checked.
  - Any of these bits nonzero is out of range.
  - Out-of-range write: suppressed.
  - Out-of-range read: read_data_o = 0.
  - In both cases error_o is asserted together with ack_o for that one cycle.
- DMEM_RANGE_CHECK_EN undefined: no error_o port, and upper bits are ignored, so addresses wrap modulo pDepth.

## Structure
- Shared package dmem_pkg: state encoding constants, default pBlockSize, pMemSize and pLatency, and the block-width helper. The cache uses the same block width.
- Sub-module dmem_block_array: single-port pDepth × (pBlockSize*8) storage with a synchronous write and a registered read.
  - FSM and counter stay in block_data_memory.

## Test plan
- Reset with enable_i = 0: all outputs 0, stays in IDLE, no ack over 20 cycles.
- Write index 5 with 0xA5 repeated, then read index 5 (pLatency = 10):
  - each ack_o occurs 10 cycles after capture;
  - the read returns the 0xA5 pattern.
- enable_i held high through ACK for 3 extra cycles: exactly one ack_o pulse. A new request is captured only after enable_i low for one cycle.
- Reset asserted 4 cycles into a write to index 7:
  - no ack_o;
  - a subsequent read of index 7 returns the old contents.
- pLatency = 1: ack_o on the edge after capture; back-to-back requests separated by one low cycle each complete.
- Address 0x0000_0200 with pDepth = 512:
  - with DMEM_RANGE_CHECK_EN: write suppressed, error_o = 1 with ack, read returns 0;
  - without it: the write aliases index 0.
